// File: rtl/if_of_pipe_reg.sv
// IF->OF pipeline register: main + skid entry, valid/ready flow control, flush, NOP bubbles.
// Optional saturating stall counter enabled by defining IF_OF_PERF_CNT_EN.
module if_of_pipe_reg #(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          PC_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h6800_0000),
  parameter int unsigned          CNT_W     = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               main_valid_q, main_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q,    main_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;

  logic accept;
  logic deliver;
  logic main_free;

  always_comb begin
    accept    = in_valid & ~skid_valid_q;
    deliver   = main_valid_q & out_ready;
    main_free = ~main_valid_q | deliver;

    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (main_free) begin
      if (skid_valid_q) begin
        // Older skid entry advances first; accept is blocked while skid is full.
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_instr_d = in_instr;
          main_pc_d    = in_pc;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
    end

    // Flush swallows any same-edge accept; a same-edge deliver has already completed.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      main_valid_q <= 1'b0;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_instr = main_valid_q ? main_instr_q : NOP_INSTR;
  assign out_pc    = main_valid_q ? main_pc_q    : '0;

`ifdef IF_OF_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_of_pipe_reg.sv
// Scoreboard bench for if_of_pipe_reg: driver pushes accepted entries, monitor pops on delivery.
// Directed reset/stream/backpressure/flush/counter cases followed by a random phase.
module tb_if_of_pipe_reg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'h6800_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic             Clk;
  logic             Rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [CNT_W-1:0] stall_cnt;

  if_of_pipe_reg #(
    .INSTR_W(32),
    .PC_W   (32),
    .CNT_W  (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc   (out_pc),
    .stall_cnt(stall_cnt)
  );

  int   total = 0;
  int   bad   = 0;
  ent_t exp_q[$];
  bit   pushed_now = 1'b0;
  int   model_cnt  = 0;
  int   occ;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endfunction

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC000_0000 ^ {pc[15:0], pc[15:0]};
  endfunction

  function automatic int exp_stall();
`ifdef IF_OF_PERF_CNT_EN
    return model_cnt;
`else
    return 0;
`endif
  endfunction

  // Drive one cycle's inputs at the falling edge; record what the coming rising edge accepts.
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                     input bit rdy, input bit fl);
    ent_t e;
    @(negedge Clk);
    in_valid  = v;
    in_instr  = v ? ins : 32'hDEAD_BEEF;
    in_pc     = v ? pc  : 32'hBAD0_BAD0;
    out_ready = rdy;
    flush     = fl;
    pushed_now = v && in_ready && Rst_n;
    if (pushed_now) begin
      e.instr = ins;
      e.pc    = pc;
      exp_q.push_back(e);
    end
  endtask

  task automatic offer(input logic [31:0] pc, input bit rdy);
    int n;
    n = 0;
    do begin
      cyc(1'b1, instr_of(pc), pc, rdy, 1'b0);
      n++;
    end while (!pushed_now && n < 50);
    chk("offer_accepted", 64'(pushed_now), 64'(1));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    in_valid   = 1'b0;
    flush      = 1'b0;
    pushed_now = 1'b0;
    Rst_n      = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // Monitor: compares DUT state against the queue of outstanding entries before each rising edge.
  always begin
    @(negedge Clk);
    #3;
    if (!Rst_n) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      occ = exp_q.size() - (pushed_now ? 1 : 0);
      chk("out_valid", 64'(out_valid), 64'(occ > 0));
      chk("in_ready", 64'(in_ready), 64'(occ < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall()));
      if (occ > 0) begin
        chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
        chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
        if (out_ready) void'(exp_q.pop_front());
        else if (model_cnt < CNT_MAX) model_cnt++;
      end else begin
        chk("bubble_instr", 64'(out_instr), 64'(NOP));
        chk("bubble_pc", 64'(out_pc), 64'(0));
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // Stream at full rate
    offer(32'h00, 1'b1);
    offer(32'h04, 1'b1);
    offer(32'h08, 1'b1);
    idle(1, 1'b1);
    chk("stream_last_pc", 64'(out_pc), 64'(32'h08));
    chk("stream_in_ready", 64'(in_ready), 64'(1));
    idle(3, 1'b1);

    // Backpressure: two held, third waits at the source
    offer(32'h10, 1'b0);
    offer(32'h14, 1'b0);
    cyc(1'b1, instr_of(32'h18), 32'h18, 1'b0, 1'b0);
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_not_taken", 64'(pushed_now), 64'(0));
    cyc(1'b1, instr_of(32'h18), 32'h18, 1'b0, 1'b0);
    chk("bp_head_stable", 64'(out_pc), 64'(32'h10));
    offer(32'h18, 1'b1);
    idle(4, 1'b1);
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Flush with both entries held and an offered instruction
    offer(32'h30, 1'b0);
    offer(32'h34, 1'b0);
    cyc(1'b1, instr_of(32'h20), 32'h20, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_nop", 64'(out_instr), 64'(NOP));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    // Flush with one held: the simultaneous accept is discarded
    offer(32'h38, 1'b0);
    cyc(1'b1, instr_of(32'h24), 32'h24, 1'b0, 1'b1);
    chk("flush_accept_taken", 64'(pushed_now), 64'(1));
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush2_valid", 64'(out_valid), 64'(0));
    offer(32'h40, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("post_flush_pc", 64'(out_pc), 64'(32'h40));
    idle(2, 1'b1);

    // Asynchronous reset mid-stream
    offer(32'h50, 1'b0);
    offer(32'h54, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    in_valid   = 1'b0;
    pushed_now = 1'b0;
    Rst_n      = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_instr", 64'(out_instr), 64'(NOP));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Stall counter saturation
    do_reset();
    offer(32'h60, 1'b0);
    idle(20, 1'b0);
`ifdef IF_OF_PERF_CNT_EN
    chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
`else
    chk("stall_off", 64'(stall_cnt), 64'(0));
`endif
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      cyc(($urandom % 4) != 0, $urandom, pc, ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    idle(4, 1'b1);
    chk("final_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
